onewire_master: RTL and testbench
=================================

# onewire_master

Bit-level 1-Wire bus master that generates reset/presence, write-slot and read-slot waveforms on a single open-drain line. It sits directly upstream of the pad's tristate buffer. Its `ow_oe` output drives the buffer enable, the buffer data input is tied to 0, and the pad value returns on `ow_in`. Host logic issues one command at a time over a valid/ready handshake and receives one response bit per command.

## Interface
Parameters:
- `CLKS_PER_US`, default 66: clock cycles per microsecond, range ≥ 2. All slot timing is derived from it.

Ports:
- `clk`, input, 1: system clock. The block uses a single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: command request.
- `cmd_ready`, output, 1: block is idle and can accept a command.
- `cmd_op`, input, 2: 0 = RESET, 1 = WRITE, 2 = READ, 3 = reserved (NOP).
- `cmd_bit`, input, 1: bit to send for WRITE; ignored for other ops.
- `rsp_valid`, output, 1: one-cycle response strobe.
- `rsp_bit`, output, 1: presence for RESET (1 = device answered), sampled bit for READ, echo of `cmd_bit` for WRITE.
- `busy`, output, 1: a slot is in progress.
- `ow_oe`, output, 1: to the tristate buffer enable. 1 = pull the line low.
- `ow_in`, input, 1: raw pad input, asynchronous.

## Operation
- Command acceptance: a command is accepted when `cmd_valid && cmd_ready`.
  - `cmd_op` and `cmd_bit` are registered on acceptance.
  - `cmd_ready` is 1 only in IDLE.
- Input synchronisation: `ow_in` passes through a 2-flop synchroniser before any use.
- States: IDLE → LOW → RELEASE → RECOVER → DONE → IDLE.
  - A microsecond counter `us_cnt` is cleared on entry to each state.
  - LOW: `ow_oe` = 1 for tLOW µs.
  - RELEASE: `ow_oe` = 0 for tSAMP µs. The synchronised input is captured at the last cycle of RELEASE.
  - RECOVER: `ow_oe` = 0 for tREC µs.
  - DONE: `rsp_valid` = 1 for one cycle, then IDLE.
- Standard timings (tLOW / tSAMP / tREC, µs):
  - RESET: 480 / 70 / 410. Presence = captured value == 0.
  - WRITE 1: 6 / 64 / 0.
  - WRITE 0: 60 / 10 / 0.
  - READ: 6 / 9 / 55. `rsp_bit` = captured value.
- tREC = 0 means RECOVER is skipped (RELEASE → DONE).
- Reserved op: accepted, goes straight to DONE, `rsp_bit` = 0, `ow_oe` is never asserted.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset values: `ow_oe` = 0, `cmd_ready` = 1, `rsp_valid` = 0, `rsp_bit` = 0, `busy` = 0. The synchroniser flops reset to 1 (idle-high line).
- `ow_oe` rises on the cycle after acceptance and stays high for exactly tLOW × `CLKS_PER_US` cycles.
- Total cycles from acceptance to `rsp_valid` = (tLOW + tSAMP + tREC) × `CLKS_PER_US` + 1.
- The earliest next acceptance is the cycle after `rsp_valid`. There is no back-to-back overlap.
- Sample-point latency: the captured value reflects the pad state 2 cycles earlier (synchroniser delay). This is accepted and is not compensated.
- `cmd_valid` held high while `busy`: ignored. `cmd_op` may change freely while not accepted.
- `rst_n` asserted mid-slot: `ow_oe` drops to 0 immediately (asynchronously), the state machine returns to IDLE, and no `rsp_valid` is issued.
- Counter width: `us_cnt` is 9 bits (max 480). The prescaler counter is sized with $clog2(`CLKS_PER_US`).

## Configuration
- `OW_OVERDRIVE_EN`, defined:
  - Adds input port `cmd_od` (1 bit), registered on acceptance.
  - `cmd_od` = 1 selects overdrive timings:
    - RESET: 70 / 9 / 40.
    - WRITE 1: 1 / 9 / 0.
    - WRITE 0: 8 / 2 / 0.
    - READ: 1 / 2 / 7.
  - `cmd_od` = 0 gives standard timings.
- `OW_OVERDRIVE_EN`, undefined: the `cmd_od` port is absent, only standard timings exist, and the overdrive constants are not compiled in.

## Structure
- Shared package `ow_pkg` holds:
  - opcode constants `OW_OP_RESET`, `OW_OP_WRITE`, `OW_OP_READ`;
  - state encodings;
  - all tLOW/tSAMP/tREC constants, standard and overdrive.
- One sub-module, `ow_us_tick`:
  - a free-running prescaler producing a one-cycle `tick` every `CLKS_PER_US` cycles;
  - a synchronous `restart` input, pulsed on every state entry so that each phase is exact to the cycle.

## Test plan
Bench uses `CLKS_PER_US` = 4 with a pull-up model on the pad.
- Presence present: RESET, device model pulls low for 60–240 µs starting 15 µs after release.
  - `ow_oe` high for exactly 1920 cycles.
  - `rsp_valid` at cycle 3841 after acceptance, `rsp_bit` = 1.
  - Repeat with no device: `rsp_bit` = 0.
- Write slots: WRITE 1 then WRITE 0.
  - Low pulses of 24 and 240 cycles; each slot is 281 cycles to `rsp_valid`.
  - `rsp_bit` echoes 1 and then 0.
- Read slots: READ with the model holding the line low 1–30 µs after slot start → `rsp_bit` = 0. READ with no hold → `rsp_bit` = 1.
- Handshake: `cmd_valid` held continuously over 3 READs.
  - `cmd_ready` is low throughout each slot.
  - Exactly 3 `rsp_valid` pulses; no command is lost or duplicated.
- Reset mid-slot: assert `rst_n` = 0 at 100 cycles into a RESET low phase.
  - `ow_oe` = 0 within the same cycle.
  - After release: `cmd_ready` = 1 and no `rsp_valid` is issued.
- Overdrive (`OW_OVERDRIVE_EN` defined): RESET with `cmd_od` = 1.
  - Low pulse of 280 cycles.
  - `rsp_valid` at cycle 477.

Source files
------------

// File: rtl/ow_pkg.sv
// Shared 1-Wire master definitions: opcodes, FSM states and slot timings in microseconds.
// Overdrive timings are only compiled when OW_OVERDRIVE_EN is defined.
package ow_pkg;

  localparam logic [1:0] OW_OP_RESET = 2'd0;
  localparam logic [1:0] OW_OP_WRITE = 2'd1;
  localparam logic [1:0] OW_OP_READ  = 2'd2;
  localparam logic [1:0] OW_OP_NOP   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_RELEASE,
    ST_RECOVER,
    ST_DONE
  } ow_state_e;

  typedef struct packed {
    logic [8:0] t_low;
    logic [8:0] t_samp;
    logic [8:0] t_rec;
  } ow_timing_t;

  localparam logic [8:0] T_RST_LOW   = 9'd480;
  localparam logic [8:0] T_RST_SAMP  = 9'd70;
  localparam logic [8:0] T_RST_REC   = 9'd410;
  localparam logic [8:0] T_W1_LOW    = 9'd6;
  localparam logic [8:0] T_W1_SAMP   = 9'd64;
  localparam logic [8:0] T_W1_REC    = 9'd0;
  localparam logic [8:0] T_W0_LOW    = 9'd60;
  localparam logic [8:0] T_W0_SAMP   = 9'd10;
  localparam logic [8:0] T_W0_REC    = 9'd0;
  localparam logic [8:0] T_RD_LOW    = 9'd6;
  localparam logic [8:0] T_RD_SAMP   = 9'd9;
  localparam logic [8:0] T_RD_REC    = 9'd55;

  function automatic ow_timing_t ow_std_timing(input logic [1:0] op, input logic wbit);
    ow_timing_t t;
    t = '0;
    case (op)
      OW_OP_RESET: begin t.t_low = T_RST_LOW; t.t_samp = T_RST_SAMP; t.t_rec = T_RST_REC; end
      OW_OP_WRITE: begin
        if (wbit) begin t.t_low = T_W1_LOW; t.t_samp = T_W1_SAMP; t.t_rec = T_W1_REC; end
        else      begin t.t_low = T_W0_LOW; t.t_samp = T_W0_SAMP; t.t_rec = T_W0_REC; end
      end
      OW_OP_READ:  begin t.t_low = T_RD_LOW; t.t_samp = T_RD_SAMP; t.t_rec = T_RD_REC; end
      default:     t = '0;
    endcase
    return t;
  endfunction

`ifdef OW_OVERDRIVE_EN
  localparam logic [8:0] TOD_RST_LOW  = 9'd70;
  localparam logic [8:0] TOD_RST_SAMP = 9'd9;
  localparam logic [8:0] TOD_RST_REC  = 9'd40;
  localparam logic [8:0] TOD_W1_LOW   = 9'd1;
  localparam logic [8:0] TOD_W1_SAMP  = 9'd9;
  localparam logic [8:0] TOD_W1_REC   = 9'd0;
  localparam logic [8:0] TOD_W0_LOW   = 9'd8;
  localparam logic [8:0] TOD_W0_SAMP  = 9'd2;
  localparam logic [8:0] TOD_W0_REC   = 9'd0;
  localparam logic [8:0] TOD_RD_LOW   = 9'd1;
  localparam logic [8:0] TOD_RD_SAMP  = 9'd2;
  localparam logic [8:0] TOD_RD_REC   = 9'd7;

  function automatic ow_timing_t ow_od_timing(input logic [1:0] op, input logic wbit);
    ow_timing_t t;
    t = '0;
    case (op)
      OW_OP_RESET: begin t.t_low = TOD_RST_LOW; t.t_samp = TOD_RST_SAMP; t.t_rec = TOD_RST_REC; end
      OW_OP_WRITE: begin
        if (wbit) begin t.t_low = TOD_W1_LOW; t.t_samp = TOD_W1_SAMP; t.t_rec = TOD_W1_REC; end
        else      begin t.t_low = TOD_W0_LOW; t.t_samp = TOD_W0_SAMP; t.t_rec = TOD_W0_REC; end
      end
      OW_OP_READ:  begin t.t_low = TOD_RD_LOW; t.t_samp = TOD_RD_SAMP; t.t_rec = TOD_RD_REC; end
      default:     t = '0;
    endcase
    return t;
  endfunction
`endif

endpackage

// File: rtl/ow_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLKS_PER_US cycles, realigned by a synchronous
// restart so that a tick lands exactly CLKS_PER_US cycles after each restart.
module ow_us_tick #(
  parameter int CLKS_PER_US = 66
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_US - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/onewire_master.sv
// Bit-level 1-Wire master generating reset/presence, write and read slots on an open-drain pad.
// Define OW_OVERDRIVE_EN to add the cmd_od port and overdrive slot timings.
module onewire_master
  import ow_pkg::*;
#(
  parameter int CLKS_PER_US = 66
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_bit,
`ifdef OW_OVERDRIVE_EN
  input  logic       cmd_od,
`endif
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       busy,
  output logic       ow_oe,
  input  logic       ow_in
);

  ow_state_e  state_q, state_d;
  logic [8:0] us_cnt_q, us_cnt_d;
  logic [1:0] op_q;
  logic       bit_q;
  logic [1:0] sync_q;
  logic       sample_q;
  logic       accept;
  logic       restart;
  logic       tick;
  logic       low_end, samp_end, rec_end;
  ow_timing_t tim;

`ifdef OW_OVERDRIVE_EN
  logic od_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      od_q <= 1'b0;
    else if (accept) od_q <= cmd_od;
  end

  assign tim = od_q ? ow_od_timing(op_q, bit_q) : ow_std_timing(op_q, bit_q);
`else
  assign tim = ow_std_timing(op_q, bit_q);
`endif

  ow_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  assign low_end  = tick && (us_cnt_q == tim.t_low  - 9'd1);
  assign samp_end = tick && (us_cnt_q == tim.t_samp - 9'd1);
  assign rec_end  = tick && (us_cnt_q == tim.t_rec  - 9'd1);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = (cmd_op == OW_OP_NOP) ? ST_DONE : ST_LOW;
        end
      end
      ST_LOW:     if (low_end)  state_d = ST_RELEASE;
      ST_RELEASE: if (samp_end) state_d = (tim.t_rec == 9'd0) ? ST_DONE : ST_RECOVER;
      ST_RECOVER: if (rec_end)  state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    restart  = (state_d != state_q);
    us_cnt_d = us_cnt_q + {8'd0, tick};
    if (restart || state_q == ST_IDLE) us_cnt_d = 9'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      us_cnt_q <= 9'd0;
    end else begin
      state_q  <= state_d;
      us_cnt_q <= us_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OW_OP_NOP;
      bit_q <= 1'b0;
    end else if (accept) begin
      op_q  <= cmd_op;
      bit_q <= cmd_bit;
    end
  end

  // The line idles high, so the synchroniser and the captured sample reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      sample_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], ow_in};
      if (state_q == ST_RELEASE && samp_end) sample_q <= sync_q[1];
    end
  end

  always_comb begin
    rsp_bit = 1'b0;
    if (state_q == ST_DONE) begin
      case (op_q)
        OW_OP_RESET: rsp_bit = ~sample_q;
        OW_OP_WRITE: rsp_bit = bit_q;
        OW_OP_READ:  rsp_bit = sample_q;
        default:     rsp_bit = 1'b0;
      endcase
    end
  end

  // Decoded straight from the state register so an asynchronous reset releases the line at once.
  assign ow_oe     = (state_q == ST_LOW);
  assign rsp_valid = (state_q == ST_DONE);
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_onewire_master.sv
// Self-checking bench for onewire_master with a pull-up pad and a simple 1-Wire device model.
// Define OW_OVERDRIVE_EN to also exercise the overdrive RESET slot.
`timescale 1ns/1ps
module tb_onewire_master;

  localparam int CPU = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic       cmd_bit = 1'b0;
`ifdef OW_OVERDRIVE_EN
  logic       cmd_od = 1'b0;
`endif
  logic       cmd_ready, rsp_valid, rsp_bit, busy, ow_oe, ow_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onewire_master #(.CLKS_PER_US(CPU)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_bit   (cmd_bit),
`ifdef OW_OVERDRIVE_EN
    .cmd_od    (cmd_od),
`endif
    .rsp_valid (rsp_valid),
    .rsp_bit   (rsp_bit),
    .busy      (busy),
    .ow_oe     (ow_oe),
    .ow_in     (ow_in)
  );

  // Device model: mode 1 answers a reset with a presence pulse starting 15 us after release,
  // mode 2 holds the line low from 1 us after a slot starts until devHoldUs.
  int  cyc = 0;
  int  startCyc = 0;
  int  relCyc = 0;
  bit  oePrev = 1'b0;
  bit  relSeen = 1'b0;
  int  devMode = 0;
  int  devDurUs = 0;
  int  devHoldUs = 0;
  logic devPull;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    oePrev <= ow_oe;
    if (ow_oe && !oePrev) begin
      startCyc <= cyc;
      relSeen  <= 1'b0;
    end
    if (!ow_oe && oePrev) begin
      relCyc  <= cyc;
      relSeen <= 1'b1;
    end
  end

  assign devPull = (devMode == 1 && relSeen && cyc >= relCyc + 15*CPU &&
                    cyc < relCyc + (15 + devDurUs)*CPU) ||
                   (devMode == 2 && cyc >= startCyc + CPU && cyc < startCyc + devHoldUs*CPU);
  assign ow_in = (ow_oe || devPull) ? 1'b0 : 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: slot shape and response straight from the timing table in microseconds.
  function automatic void refSlot(input int op, input bit b, input bit od, input bit devLow,
                                  output int expLow, output int expLat, output int expBit);
    int tl, ts, tr;
    tl = 0; ts = 0; tr = 0;
    if (!od) begin
      case (op)
        0: begin tl = 480; ts = 70; tr = 410; end
        1: begin tl = b ? 6 : 60; ts = b ? 64 : 10; tr = 0; end
        2: begin tl = 6; ts = 9; tr = 55; end
        default: ;
      endcase
    end else begin
      case (op)
        0: begin tl = 70; ts = 9; tr = 40; end
        1: begin tl = b ? 1 : 8; ts = b ? 9 : 2; tr = 0; end
        2: begin tl = 1; ts = 2; tr = 7; end
        default: ;
      endcase
    end
    if (op == 3) begin
      expLow = 0; expLat = 1; expBit = 0;
    end else begin
      expLow = tl * CPU;
      expLat = (tl + ts + tr) * CPU + 1;
      case (op)
        0:       expBit = devLow ? 1 : 0;
        1:       expBit = b ? 1 : 0;
        default: expBit = devLow ? 0 : 1;
      endcase
    end
  endfunction

  task automatic applyStimulus(input int op, input bit b, input bit od, input int mode,
                               input int dur, input int hold, input string tag);
    int k, lowCnt, lat, gotBit, readyBad;
    int expLow, expLat, expBit;
    refSlot(op, b, od, (mode != 0), expLow, expLat, expBit);
    devMode   = mode;
    devDurUs  = dur;
    devHoldUs = hold;
    @(negedge clk);
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_bit   = b;
`ifdef OW_OVERDRIVE_EN
    cmd_od    = od;
`endif
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_bit   = 1'($urandom);
    k = 1; lowCnt = 0; lat = -1; gotBit = -1; readyBad = 0;
    while (lat < 0 && k < 5000) begin
      if (ow_oe) lowCnt++;
      if (cmd_ready) readyBad++;
      if (rsp_valid) begin
        lat    = k;
        gotBit = rsp_bit;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " low_cycles"}, lowCnt, expLow);
    checkOutput({tag, " rsp_bit"}, gotBit, expBit);
    checkOutput({tag, " ready_during_slot"}, readyBad, 0);
    devMode = 0;
  endtask

  initial begin
    int pulses, lastAt, readyBad, extra, bitBad, k, op, mode;
    bit b;

    #12;
    checkOutput("reset ow_oe", ow_oe, 0);
    checkOutput("reset cmd_ready", cmd_ready, 1);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset rsp_bit", rsp_bit, 0);
    checkOutput("reset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus(0, 1'b0, 1'b0, 1, 100, 0, "reset_present");
    applyStimulus(0, 1'b0, 1'b0, 0, 0, 0, "reset_absent");
    applyStimulus(1, 1'b1, 1'b0, 0, 0, 0, "write1");
    applyStimulus(1, 1'b0, 1'b0, 0, 0, 0, "write0");
    applyStimulus(2, 1'b0, 1'b0, 2, 0, 30, "read_held");
    applyStimulus(2, 1'b0, 1'b0, 0, 0, 0, "read_free");
    applyStimulus(3, 1'b1, 1'b0, 0, 0, 0, "nop");

    // Continuous cmd_valid over three READ slots.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    pulses = 0; lastAt = -1; readyBad = 0; bitBad = 0; k = 0;
    while (pulses < 3 && k < 2000) begin
      @(negedge clk);
      k++;
      if (busy && cmd_ready) readyBad++;
      if (rsp_valid) begin
        pulses++;
        lastAt = k;
        if (rsp_bit !== 1'b1) bitBad++;
        if (pulses == 3) cmd_valid = 1'b0;
      end
    end
    extra = 0;
    repeat (400) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    checkOutput("hs pulses", pulses, 3);
    checkOutput("hs third_pulse_cycle", lastAt, 3*281 + 2);
    checkOutput("hs ready_while_busy", readyBad, 0);
    checkOutput("hs read_bits", bitBad, 0);
    checkOutput("hs extra_pulses", extra, 0);

    // Asynchronous reset 100 cycles into a RESET low phase.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (99) @(negedge clk);
    checkOutput("midrst oe_before", ow_oe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst oe_after", ow_oe, 0);
    checkOutput("midrst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (4000) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    checkOutput("midrst rsp_pulses", extra, 0);
    checkOutput("midrst cmd_ready", cmd_ready, 1);

`ifdef OW_OVERDRIVE_EN
    applyStimulus(0, 1'b0, 1'b1, 0, 0, 0, "od_reset");
    applyStimulus(2, 1'b0, 1'b1, 2, 0, 20, "od_read_held");
`endif

    for (int i = 0; i < 10; i++) begin
      op   = int'($urandom_range(0, 3));
      b    = 1'($urandom);
      mode = 0;
      if ($urandom_range(0, 1) == 1) begin
        if (op == 0) mode = 1;
        if (op == 2) mode = 2;
      end
      applyStimulus(op, b, 1'b0, mode, int'($urandom_range(60, 240)),
                    int'($urandom_range(16, 30)), $sformatf("rand%0d_op%0d", i, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
